// File: rtl/mips_mc_controller_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state encodings,
// opcode/funct constants and datapath select codes.
package mips_mc_controller_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC_R  = 4'd7,
        S_RWB     = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_JAL     = 4'd11,
        S_JR      = 4'd12,
        S_ADDI_EX = 4'd13,
        S_ADDI_WB = 4'd14,
        S_ERR     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mips_mc_controller_mem_wait_timer.sv
// Counts memory wait cycles within one access; flags a timeout when the
// MEM_TIMEOUT-th consecutive wait cycle passes without ready.
module mips_mc_controller_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic ready,
    output logic timeout
);

    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !ready) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Ready in the final allowed cycle wins over the timeout.
    assign timeout = enable && !ready && (cnt == LAST_WAIT);

endmodule

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control sequencer: Moore strobes from the state register,
// memory exits qualified by mem_ready, sticky error on timeout or bad opcode.
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE      | first cycle after reset
// FETCH     | read instruction, PC += 4 on ready
// DECODE    | register read, branch target into ALUOut
// MEMADR    | lw/sw effective address
// MEMRD     | lw data read
// MEMWB     | lw register writeback
// MEMWR     | sw data write
// EXEC_R    | R-type ALU operation
// RWB       | R-type register writeback
// BRANCH    | beq compare and conditional PC update
// JUMP      | j
// JAL       | jal, link into r31
// JR        | jr, PC from rs
// ADDI_EX   | addi ALU operation
// ADDI_WB   | addi register writeback
// ERR       | sticky error, held until reset
module mips_mc_controller
    import mips_mc_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUsrcA,
    output logic [1:0] ALUsrcB,
    output logic [1:0] ALUop,
    output logic [1:0] PCSource,
    output logic       jump_link,
    output logic       jump_reg,
    output logic       instr_done,
    output logic       err,
    output logic [1:0] err_code,
    output logic [3:0] state_o
);

    state_t     state, state_next;
    logic [1:0] err_code_next;
    logic       timer_clear, timeout;

    // The zero flag is combined with PCWriteCond inside the datapath.
    logic unused_zero;
    assign unused_zero = zero;

    assign timer_clear = (state_next != state) && is_mem_state(state_next);

    mips_mc_controller_mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (is_mem_state(state)),
        .ready  (mem_ready),
        .timeout(timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            err_code <= ERR_NONE;
        end else begin
            state    <= state_next;
            err_code <= err_code_next;
        end
    end

    always_comb begin
        state_next    = state;
        err_code_next = err_code;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        MemtoReg      = 1'b0;
        RegDst        = 1'b0;
        RegWrite      = 1'b0;
        ALUsrcA       = 1'b0;
        ALUsrcB       = SRCB_REG;
        ALUop         = ALUOP_ADD;
        PCSource      = PCSRC_ALU;
        jump_link     = 1'b0;
        jump_reg      = 1'b0;
        instr_done    = 1'b0;
        err           = 1'b0;

        case (state)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                ALUsrcB = SRCB_FOUR;
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout) begin
                    state_next    = S_ERR;
                    err_code_next = ERR_TIMEOUT;
                end
            end
            S_DECODE: begin
                ALUsrcB = SRCB_IMM_SH2;
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXEC_R;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_JAL:       state_next = S_JAL;
                    OP_ADDI:      state_next = S_ADDI_EX;
                    default: begin
                        state_next    = S_ERR;
                        err_code_next = ERR_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUsrcA    = 1'b1;
                ALUsrcB    = SRCB_IMM;
                state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    state_next = S_MEMWB;
                end else if (timeout) begin
                    state_next    = S_ERR;
                    err_code_next = ERR_TIMEOUT;
                end
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end else if (timeout) begin
                    state_next    = S_ERR;
                    err_code_next = ERR_TIMEOUT;
                end
            end
            S_EXEC_R: begin
                ALUsrcA    = 1'b1;
                ALUop      = ALUOP_FUNCT;
                state_next = (funct == FN_JR) ? S_JR : S_RWB;
            end
            S_RWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUsrcA     = 1'b1;
                ALUop       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                instr_done  = 1'b1;
                state_next  = S_FETCH;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                RegWrite   = 1'b1;
                jump_link  = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_JR: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_REG;
                jump_reg   = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_ADDI_EX: begin
                ALUsrcA    = 1'b1;
                ALUsrcB    = SRCB_IMM;
                state_next = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_ERR: err = 1'b1;
            default: state_next = S_ERR;
        endcase
    end

    assign state_o = state;

endmodule
